// File: rtl/pulse_timer_arb_if.sv
// Bus bundle for pulse_timer_arb: the requester side drives Req/Tc/Abort.
// The timer side returns Gnt/Done/Busy/Cnt.
// Each requester's terminal count is Tc[i*CNT_W +: CNT_W].
interface pulse_timer_arb_if #(
    parameter int N_REQ = 3,
    parameter int CNT_W = 18
);
    logic [N_REQ-1:0]       Req;
    logic [N_REQ*CNT_W-1:0] Tc;
    logic                   Abort;
    logic [N_REQ-1:0]       Gnt;
    logic [N_REQ-1:0]       Done;
    logic                   Busy;
    logic [CNT_W-1:0]       Cnt;

    modport master (
        output Req, Tc, Abort,
        input  Gnt, Done, Busy, Cnt
    );

    modport slave (
        input  Req, Tc, Abort,
        output Gnt, Done, Busy, Cnt
    );
endinterface

// File: rtl/pulse_timer_arb.sv
// Shared delay timer with a round-robin arbiter.
// One synchronous counter serves N_REQ requesters. The winner's terminal
// count is latched at grant time. The block counts from 0 up to that value
// and then gives the winner a single-cycle Done pulse.
// Optional build macro PULSE_TIMER_ARB_FIXED_PRIO_EN: the search pointer is
// pinned at 0, which gives fixed priority with index 0 highest.
module pulse_timer_arb #(
    parameter int N_REQ = 3,
    parameter int CNT_W = 18
) (
    input  logic              Clk,
    input  logic              Rst_n,
    pulse_timer_arb_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] tc_q, tc_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    // Unpack the flat terminal-count bus into one word per requester
    logic [CNT_W-1:0] tc_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_tc_unpack
            assign tc_arr[gi] = bus.Tc[gi*CNT_W +: CNT_W];
        end
    endgenerate

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] scan_pos;

    // Find the first request at or above the pointer, wrapping modulo N_REQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = ptr_q;
        for (int k = 0; k < N_REQ; k++) begin
            if (!win_found && bus.Req[scan_pos]) begin
                win_found = 1'b1;
                win_idx   = scan_pos;
            end
            scan_pos = (scan_pos == LAST_IDX) ? '0 : scan_pos + 1'b1;
        end
    end

    // Next-state logic and registered (Moore) output values
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        tc_d    = tc_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = COUNT;
                    gnt_d   = N_REQ'(1) << win_idx;
                    idx_d   = win_idx;
                    tc_d    = tc_arr[win_idx];
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end

            COUNT: begin
                // A cancel by Abort or by the requester dropping Req leaves
                // the pointer alone, so the same requester stays first in line.
                if (bus.Abort || ((bus.Req & gnt_q) == '0)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == tc_q) begin
                    // Exit on equality before incrementing, so an all-ones
                    // terminal count never wraps the counter.
                    state_d = DONE;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            DONE: begin
                // Abort is not looked at here; the pulse always completes.
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
`ifdef PULSE_TIMER_ARB_FIXED_PRIO_EN
                ptr_d   = '0;
`else
                ptr_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
`endif
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            tc_q    <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.Gnt  = gnt_q;
    assign bus.Done = done_q;
    assign bus.Busy = busy_q;
    assign bus.Cnt  = cnt_q;

endmodule
